ascon_sbox_ti_slicer: RTL and testbench

Sequential, parametrised 3-share threshold-implementation (TI) substitution layer for the full 320-bit Ascon state. It takes a three-share masked state, runs it through the team's first-order TI 5-bit S-box share functions `LANES` columns per cycle, and registers every share-function output before reuse, which gives the glitch barrier that TI requires. It sits between the masked constant-addition and linear-diffusion stages of the masked permutation and uses valid/ready handshakes on both sides.

---
 rtl/ascon_sbox_ti_slicer.sv | 143 ++++++++++++++
 tb/tb_ascon_sbox_ti_slicer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_sbox_ti_slicer.sv
// Three-share threshold-implementation Ascon S-box layer for the 320-bit state.
// LANES columns are processed per cycle. Every share-function output is registered before it is reused.

module ascon_sbox_ti_share #(
    parameter bit INV = 1'b0
) (
    input  logic [4:0] a,
    input  logic [4:0] b,
    output logic [4:0] y
);
    // Bit i holds Ascon variable x_i.
    // a supplies the linear terms and the a*a products; b enters only through cross products.
    logic [4:0] pa, pb, c;

    assign pa = {a[4] ^ a[3], a[3], a[2] ^ a[1], a[1], a[0] ^ a[4]};
    assign pb = {b[4] ^ b[3], b[3], b[2] ^ b[1], b[1], b[0] ^ b[4]};

    for (genvar i = 0; i < 5; i++) begin : g_chi
        localparam int J = (i + 1) % 5;
        localparam int K = (i + 2) % 5;
        assign c[i] = pa[i] ^ pa[K] ^ (pa[J] & pa[K]) ^ (pa[J] & pb[K]) ^ (pb[J] & pa[K]);
    end

    // The final complement of x2 is applied in exactly one share.
    assign y = {c[4], c[3] ^ c[2], c[2] ^ INV, c[1] ^ c[0], c[0] ^ c[4]};
endmodule

module ascon_sbox_ti_slicer #(
    parameter int LANES = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [319:0] in_s0,
    input  logic [319:0] in_s1,
    input  logic [319:0] in_s2,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [319:0] out_s0,
    output logic [319:0] out_s1,
    output logic [319:0] out_s2,
    output logic         busy
);
    localparam int N  = 64 / LANES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 ||
          LANES == 16 || LANES == 32 || LANES == 64)) begin : g_bad_lanes
        $error("ascon_sbox_ti_slicer: LANES must be 1, 2, 4, 8, 16, 32 or 64");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                   state_q, state_d;
    logic [CW-1:0]            ctr_q, ctr_d;
    logic [2:0][319:0]        in_q, in_d, out_q, out_d;
    logic                     in_ready_q, in_ready_d;
    logic                     out_valid_q, out_valid_d;
    logic                     busy_q, busy_d;
    logic [LANES-1:0][2:0][4:0] lane_x, lane_y;

    function automatic logic [8:0] bit_idx(input int word, input int col);
        return 9'(64 * word + col);
    endfunction

    always_comb begin
        lane_x = '0;
        for (int l = 0; l < LANES; l++)
            for (int s = 0; s < 3; s++)
                for (int i = 0; i < 5; i++)
                    lane_x[l][s][i] = in_q[s][bit_idx(i, int'(ctr_q) * LANES + l)];
    end

    // Output share j is computed from input shares j+1 and j+2 only.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        ascon_sbox_ti_share #(.INV(1'b1)) u_sh0 (.a(lane_x[l][1]), .b(lane_x[l][2]), .y(lane_y[l][0]));
        ascon_sbox_ti_share #(.INV(1'b0)) u_sh1 (.a(lane_x[l][2]), .b(lane_x[l][0]), .y(lane_y[l][1]));
        ascon_sbox_ti_share #(.INV(1'b0)) u_sh2 (.a(lane_x[l][0]), .b(lane_x[l][1]), .y(lane_y[l][2]));
    end

    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        in_d    = in_q;
        out_d   = out_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    in_d    = {in_s2, in_s1, in_s0};
                    ctr_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int l = 0; l < LANES; l++)
                    for (int s = 0; s < 3; s++)
                        for (int i = 0; i < 5; i++)
                            out_d[s][bit_idx(i, int'(ctr_q) * LANES + l)] = lane_y[l][s][i];
                ctr_d = ctr_q + CW'(1);
                if (ctr_q == CW'(N - 1)) begin
                    ctr_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // The handshake outputs are registered so that no input reaches them combinationally.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ctr_q       <= '0;
            in_q        <= '0;
            out_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctr_q       <= ctr_d;
            in_q        <= in_d;
            out_q       <= out_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_s0    = out_q[0];
    assign out_s1    = out_q[1];
    assign out_s2    = out_q[2];
endmodule

// File: tb/tb_ascon_sbox_ti_slicer.sv
// Directed bench for ascon_sbox_ti_slicer.
// Three instances use LANES = 8, 1 and 64; the unmasked results are checked against the Ascon S-box table.

module tb_ascon_sbox_ti_slicer;
    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
    localparam int NN [3] = '{8, 64, 1};

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [319:0] s0, s1, s2;
    logic iv [3];
    logic ir [3];
    logic ov [3];
    logic ordy [3];
    logic bz [3];
    logic [319:0] o0 [3];
    logic [319:0] o1 [3];
    logic [319:0] o2 [3];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ascon_sbox_ti_slicer #(.LANES(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_s0(s0), .in_s1(s1), .in_s2(s2), .out_valid(ov[0]), .out_ready(ordy[0]),
        .out_s0(o0[0]), .out_s1(o1[0]), .out_s2(o2[0]), .busy(bz[0]));
    ascon_sbox_ti_slicer #(.LANES(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_s0(s0), .in_s1(s1), .in_s2(s2), .out_valid(ov[1]), .out_ready(ordy[1]),
        .out_s0(o0[1]), .out_s1(o1[1]), .out_s2(o2[1]), .busy(bz[1]));
    ascon_sbox_ti_slicer #(.LANES(64)) u_dut64 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_s0(s0), .in_s1(s1), .in_s2(s2), .out_valid(ov[2]), .out_ready(ordy[2]),
        .out_s0(o0[2]), .out_s1(o1[2]), .out_s2(o2[2]), .busy(bz[2]));

    function automatic logic [319:0] rnd320();
        logic [319:0] r;
        for (int i = 0; i < 10; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [4:0] col_of(input logic [319:0] v, input int c);
        return {v[c], v[64+c], v[128+c], v[192+c], v[256+c]};
    endfunction

    function automatic logic [319:0] set_col(input logic [319:0] v, input int c, input logic [4:0] x);
        logic [319:0] r;
        r = v;
        r[c] = x[4]; r[64+c] = x[3]; r[128+c] = x[2]; r[192+c] = x[1]; r[256+c] = x[0];
        return r;
    endfunction

    function automatic logic [319:0] sbox_ref(input logic [319:0] v);
        logic [319:0] r;
        r = '0;
        for (int c = 0; c < 64; c++) r = set_col(r, c, SBOX[col_of(v, c)]);
        return r;
    endfunction

    task automatic mask3(input logic [319:0] v);
        s0 = rnd320();
        s1 = rnd320();
        s2 = v ^ s0 ^ s1;
    endtask

    // Caller guarantees in_ready of instance d is high; lat counts edges from the accept edge inclusive.
    task automatic do_op(input int d, output int lat, output logic [319:0] res);
        iv[d] = 1'b1;
        @(posedge clk); #1;
        iv[d] = 1'b0;
        lat = 1;
        while (!ov[d] && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        res = o0[d] ^ o1[d] ^ o2[d];
    endtask

    task automatic finish_op(input int d);
        ordy[d] = 1'b1;
        @(posedge clk); #1;
        ordy[d] = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #2;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({ir[d], ov[d], bz[d]} !== 3'b000 || {o0[d], o1[d], o2[d]} !== '0) begin
                errors++;
                $display("FAIL reset_state dut%0d: rdy/vld/busy=%b%b%b outputs_nonzero=%b, required 000 and zero",
                         d, ir[d], ov[d], bz[d], |{o0[d], o1[d], o2[d]});
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (ir[d] !== 1'b1) begin
                errors++;
                $display("FAIL reset_release_ready dut%0d: got %b required 1", d, ir[d]);
            end
        end
    endtask

    task automatic test_zero();
        int lat;
        logic [319:0] r;
        s0 = '0; s1 = '0; s2 = '0;
        do_op(0, lat, r);
        checks++;
        if (lat !== 9) begin
            errors++;
            $display("FAIL zero_latency: got %0d required 9", lat);
        end
        checks++;
        if (r !== {64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0}) begin
            errors++;
            $display("FAIL zero_result: got %h required x2 all-ones, other words zero", r);
        end
        finish_op(0);
    endtask

    task automatic test_ones();
        int lat;
        logic [319:0] r, ones, expv;
        ones = {320{1'b1}};
        expv = {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
        s0 = ones; s1 = '0; s2 = '0;
        do_op(0, lat, r);
        checks++;
        if (r !== expv) begin
            errors++;
            $display("FAIL ones_share0: got %h required %h", r, expv);
        end
        finish_op(0);
        mask3(ones);
        do_op(0, lat, r);
        checks++;
        if (r !== expv) begin
            errors++;
            $display("FAIL ones_masked: got %h required %h", r, expv);
        end
        finish_op(0);
    endtask

    task automatic test_sweep();
        int lat;
        logic [319:0] r, v;
        v = '0;
        for (int c = 0; c < 64; c++) v = set_col(v, c, 5'(c % 32));
        for (int d = 0; d < 3; d++) begin
            mask3(v);
            do_op(d, lat, r);
            checks++;
            if (lat !== NN[d] + 1) begin
                errors++;
                $display("FAIL sweep_latency dut%0d: got %0d required %0d", d, lat, NN[d] + 1);
            end
            for (int c = 0; c < 64; c++) begin
                checks++;
                if (col_of(r, c) !== SBOX[c % 32]) begin
                    errors++;
                    $display("FAIL sweep_column dut%0d col %0d: got %h required %h",
                             d, c, col_of(r, c), SBOX[c % 32]);
                end
            end
            finish_op(d);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [319:0] r, v;
        logic [959:0] snap;
        v = rnd320();
        mask3(v);
        do_op(0, lat, r);
        checks++;
        if (r !== sbox_ref(v)) begin
            errors++;
            $display("FAIL bp_result: got %h required %h", r, sbox_ref(v));
        end
        snap = {o2[0], o1[0], o0[0]};
        for (int k = 0; k < 10; k++) begin
            iv[0] = (k % 2 == 0);
            mask3(rnd320());
            @(posedge clk); #1;
            checks++;
            if ({o2[0], o1[0], o0[0]} !== snap || ir[0] !== 1'b0 || ov[0] !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: stable=%b ready=%b valid=%b required stable=1 ready=0 valid=1",
                         k, {o2[0], o1[0], o0[0]} === snap, ir[0], ov[0]);
            end
        end
        iv[0] = 1'b0;
        finish_op(0);
        checks++;
        if ({ir[0], ov[0], bz[0]} !== 3'b100) begin
            errors++;
            $display("FAIL bp_release: rdy/vld/busy=%b%b%b required 100", ir[0], ov[0], bz[0]);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [319:0] r, v;
        mask3(rnd320());
        iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({ir[0], ov[0], bz[0]} !== 3'b000 || {o0[0], o1[0], o2[0]} !== '0) begin
            errors++;
            $display("FAIL reset_mid: rdy/vld/busy=%b%b%b outputs_nonzero=%b required 000 and zero",
                     ir[0], ov[0], bz[0], |{o0[0], o1[0], o2[0]});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (ir[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_ready: got %b required 1", ir[0]);
        end
        v = rnd320();
        mask3(v);
        do_op(0, lat, r);
        checks++;
        if (lat !== 9 || r !== sbox_ref(v)) begin
            errors++;
            $display("FAIL reset_mid_next_op: latency %0d result %h required 9 and %h", lat, r, sbox_ref(v));
        end
        finish_op(0);
    endtask

    task automatic test_back_to_back();
        logic [319:0] va, vb;
        logic [319:0] got [2];
        int acc_cyc [2];
        int acc, res;
        logic accept_now;
        va = rnd320();
        vb = rnd320();
        got[0] = '0; got[1] = '0;
        acc_cyc[0] = 0; acc_cyc[1] = 0;
        acc = 0; res = 0;
        mask3(va);
        iv[0] = 1'b1;
        ordy[0] = 1'b1;
        for (int cyc = 0; cyc < 60 && res < 2; cyc++) begin
            accept_now = iv[0] && ir[0];
            if (ov[0]) begin
                got[res] = o0[0] ^ o1[0] ^ o2[0];
                res++;
            end
            @(posedge clk); #1;
            if (accept_now && acc < 2) begin
                acc_cyc[acc] = cyc;
                acc++;
                if (acc == 1) mask3(vb);
                if (acc == 2) iv[0] = 1'b0;
            end
        end
        iv[0] = 1'b0;
        ordy[0] = 1'b0;
        checks++;
        if (acc !== 2 || res !== 2) begin
            errors++;
            $display("FAIL b2b_progress: accepts %0d results %0d required 2 and 2", acc, res);
        end
        checks++;
        if (acc_cyc[1] - acc_cyc[0] !== 10) begin
            errors++;
            $display("FAIL b2b_interval: got %0d required 10", acc_cyc[1] - acc_cyc[0]);
        end
        checks++;
        if (got[0] !== sbox_ref(va)) begin
            errors++;
            $display("FAIL b2b_first: got %h required %h", got[0], sbox_ref(va));
        end
        checks++;
        if (got[1] !== sbox_ref(vb)) begin
            errors++;
            $display("FAIL b2b_second: got %h required %h", got[1], sbox_ref(vb));
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            iv[d] = 1'b0;
            ordy[d] = 1'b0;
        end
        s0 = '0; s1 = '0; s2 = '0;
        test_reset();
        test_zero();
        test_ones();
        test_sweep();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
